// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU issue stage: instruction field
//               positions, default register-file geometry and ALU opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default geometry
    localparam int DEF_NREGS = 8;
    localparam int DEF_XLEN  = 32;
    localparam int ILEN      = 32;

    // Instruction word field positions
    localparam int OP_LSB  = 0;
    localparam int OP_MSB  = 4;
    localparam int RD_LSB  = 5;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 11;

    // Integer ALU opcodes
    localparam logic [4:0] OP_INT_ADD = 5'b10000;
    localparam logic [4:0] OP_INT_SUB = 5'b10001;
    localparam logic [4:0] OP_INT_X3  = 5'b10011;
    localparam logic [4:0] OP_INT_X7  = 5'b10111;

    // Floating-point ALU opcodes
    localparam logic [4:0] OP_FP_ADD  = 5'b01000;
    localparam logic [4:0] OP_FP_X1   = 5'b01001;
    localparam logic [4:0] OP_FP_X3   = 5'b01011;
    localparam logic [4:0] OP_FP_X7   = 5'b01111;

    // True for opcodes handled by the floating-point side of the ALU
    function automatic logic is_fp_op(input logic [4:0] op);
        return (op[4:3] == 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : NREGS x XLEN register file, two asynchronous read ports and
//               two write ports. The writeback port has priority over the
//               host port when both target the same register.
// Ports       : clk, rst_n (async active-low clear)
//               rd1_addr/rd1_data, rd2_addr/rd2_data : read ports
//               wb_en/wb_addr/wb_data                : writeback (priority)
//               host_en/host_addr/host_data          : host write
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int XLEN  = DEF_XLEN,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd1_addr,
    output logic [XLEN-1:0] rd1_data,
    input  logic [AW-1:0]   rd2_addr,
    output logic [XLEN-1:0] rd2_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            host_en,
    input  logic [AW-1:0]   host_addr,
    input  logic [XLEN-1:0] host_data
);

    logic [XLEN-1:0] w_regs [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (wb_en && (wb_addr == AW'(gi))) begin
                    r_q <= wb_data;
                end else if (host_en && (host_addr == AW'(gi))) begin
                    r_q <= host_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    // Reads see the stored value only; same-cycle writes are not bypassed.
    assign rd1_data = w_regs[rd1_addr];
    assign rd2_data = w_regs[rd2_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Issue / operand-fetch stage in front of the ALU. Accepts an
//               instruction over valid/ready, reads rs1/rs2 from the register
//               file, drives the ALU for one cycle and writes the result back
//               to rd on the following edge, pulsing res_valid.
// Config      : ALU_ISSUE_FORWARD_EN - when defined, a RAW hazard against the
//               instruction in the ALU is resolved by forwarding alu_s; when
//               undefined the stage stalls one cycle on such a hazard.
// Ports       : clk, rst_n (async active-low)
//               in_valid/in_ready/in_instr : instruction handshake
//               wr_en/wr_addr/wr_data      : host register write
//               alu_a/alu_b/alu_instr      : to ALU; alu_s/alu_ze from ALU
//               res_valid/res_data/res_zero/res_rd : writeback report
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int XLEN  = DEF_XLEN,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [ILEN-1:0] alu_instr,
    input  logic [XLEN-1:0] alu_s,
    input  logic            alu_ze,
    output logic            res_valid,
    output logic [XLEN-1:0] res_data,
    output logic            res_zero,
    output logic [AW-1:0]   res_rd
);

    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [XLEN-1:0] w_rf_a;
    logic [XLEN-1:0] w_rf_b;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic            w_hit1;
    logic            w_hit2;
    logic            w_accept;

    logic            r_run;
    logic            r_ex_valid;
    logic [AW-1:0]   r_ex_rd;
    logic [XLEN-1:0] r_ex_a;
    logic [XLEN-1:0] r_ex_b;
    logic [ILEN-1:0] r_ex_instr;

    assign w_rd  = in_instr[RD_LSB  +: AW];
    assign w_rs1 = in_instr[RS1_LSB +: AW];
    assign w_rs2 = in_instr[RS2_LSB +: AW];

    // Source operand matches the destination of the instruction in the ALU
    assign w_hit1 = r_ex_valid && (w_rs1 == r_ex_rd);
    assign w_hit2 = r_ex_valid && (w_rs2 == r_ex_rd);

`ifdef ALU_ISSUE_FORWARD_EN
    assign w_op_a   = w_hit1 ? alu_s : w_rf_a;
    assign w_op_b   = w_hit2 ? alu_s : w_rf_b;
    assign in_ready = r_run;
`else
    // Stall until the writeback has landed in the register file
    assign w_op_a   = w_rf_a;
    assign w_op_b   = w_rf_b;
    assign in_ready = r_run && !(w_hit1 || w_hit2);
`endif

    assign w_accept = in_valid && in_ready;

    // r_run keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Execute stage: operands and instruction held for the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_instr <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_rd    <= w_rd;
                r_ex_a     <= w_op_a;
                r_ex_b     <= w_op_b;
                r_ex_instr <= in_instr;
            end
        end
    end

    // Result report; data/zero/rd hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_rd    <= '0;
        end else begin
            res_valid <= r_ex_valid;
            if (r_ex_valid) begin
                res_data <= alu_s;
                res_zero <= alu_ze;
                res_rd   <= r_ex_rd;
            end
        end
    end

    assign alu_a     = r_ex_a;
    assign alu_b     = r_ex_b;
    assign alu_instr = r_ex_instr;

    alu_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd1_addr  (w_rs1),
        .rd1_data  (w_rf_a),
        .rd2_addr  (w_rs2),
        .rd2_data  (w_rf_b),
        .wb_en     (r_ex_valid),
        .wb_addr   (r_ex_rd),
        .wb_data   (alu_s),
        .host_en   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue. A stand-in ALU drives
//               alu_s/alu_ze; an architectural model (register array plus the
//               one pending result) predicts operands and results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
    import alu_pkg::*;

`ifdef ALU_ISSUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        in_ready;
    logic [31:0] alu_a, alu_b, alu_instr, alu_s, res_data;
    logic        alu_ze, res_valid, res_zero;
    logic [2:0]  res_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model
    logic [31:0] m_regs [8];
    bit          m_pend;
    logic [2:0]  m_prd;
    logic [31:0] m_pres;
    bit          m_run;
    logic        e_res_valid, e_res_zero;
    logic [31:0] e_res_data, e_a, e_b, e_instr;
    logic [2:0]  e_res_rd;

    logic [4:0] ops [8] = '{OP_INT_ADD, OP_INT_SUB, OP_INT_X3, OP_INT_X7,
                            OP_FP_ADD, OP_FP_X1, OP_FP_X3, OP_FP_X7};

    always #5 clk = ~clk;

    // Stand-in ALU: integer add/sub/and/or; float add only knows the
    // 3.2 + -1.3 pair, other float ops return a fixed scramble.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_INT_ADD: return a + b;
            OP_INT_SUB: return a - b;
            OP_INT_X3:  return a & b;
            OP_INT_X7:  return a | b;
            OP_FP_ADD:  return (a == 32'h404CCCCD && b == 32'hBFA66666) ? 32'h3FF33333 : (a ^ b ^ 32'h3F800000);
            default:    return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    assign alu_s  = ref_alu(alu_instr[4:0], alu_a, alu_b);
    assign alu_ze = (alu_s == 32'h0);

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_instr (alu_instr),
        .alu_s     (alu_s),
        .alu_ze    (alu_ze),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_rd    (res_rd)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        logic [17:0] hi;
        hi = 18'($urandom);
        return {hi, rs2, rs1, rd, op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_pend = 0; m_prd = '0; m_pres = '0; m_run = 0;
        e_res_valid = 0; e_res_zero = 0; e_res_data = '0; e_res_rd = '0;
        e_a = '0; e_b = '0; e_instr = '0;
    endtask

    // One clock: check in_ready, advance the model, check registered outputs.
    // Called and returns at a falling edge; clears in_valid/wr_en on return.
    task automatic cycle(output bit acc, output bit dut_ready);
        logic [31:0] v [8];
        bit haz, exp_ready;
        logic [2:0] rs1, rs2;
        #1;
        rs1 = in_instr[10:8];
        rs2 = in_instr[13:11];
        haz = m_pend && (rs1 == m_prd || rs2 == m_prd);
        exp_ready = m_run && (FWD || !haz);
        dut_ready = in_ready;
        n_checks++;
        if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, exp_ready);
        end
        acc = in_valid && exp_ready;
        @(posedge clk);
        // Architectural view = register array with the pending result applied
        for (int i = 0; i < 8; i++) v[i] = m_regs[i];
        if (m_pend) v[m_prd] = m_pres;
        e_res_valid = m_pend;
        if (m_pend) begin
            e_res_data = m_pres;
            e_res_zero = (m_pres == 32'h0);
            e_res_rd   = m_prd;
        end
        if (wr_en) m_regs[wr_addr] = wr_data;
        if (m_pend) m_regs[m_prd] = m_pres;
        if (acc) begin
            e_a     = v[rs1];
            e_b     = v[rs2];
            e_instr = in_instr;
            m_pres  = ref_alu(in_instr[4:0], v[rs1], v[rs2]);
            m_prd   = in_instr[7:5];
            m_pend  = 1;
        end else begin
            m_pend  = 0;
        end
        m_run = 1;
        #1;
        n_checks++;
        if ({res_valid, res_zero, res_rd, res_data} !== {e_res_valid, e_res_zero, e_res_rd, e_res_data}) begin
            n_fail++;
            $display("FAIL result @%0t: got v=%b z=%b rd=%0d d=%h want v=%b z=%b rd=%0d d=%h", $time,
                     res_valid, res_zero, res_rd, res_data, e_res_valid, e_res_zero, e_res_rd, e_res_data);
        end
        n_checks++;
        if ({alu_a, alu_b, alu_instr} !== {e_a, e_b, e_instr}) begin
            n_fail++;
            $display("FAIL alu_drive @%0t: got a=%h b=%h i=%h want a=%h b=%h i=%h", $time,
                     alu_a, alu_b, alu_instr, e_a, e_b, e_instr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic idle();
        bit a, r;
        cycle(a, r);
    endtask

    task automatic hostwr(input logic [2:0] addr, input logic [31:0] data);
        bit a, r;
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        cycle(a, r);
    endtask

    // Offer an instruction until accepted; stalls counts cycles the DUT held in_ready low
    task automatic issue(input logic [31:0] instr, output int stalls);
        bit a, r;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_instr = instr;
            cycle(a, r);
            if (!r) stalls++;
            if (a) return;
        end
        n_checks++; n_fail++;
        $display("FAIL issue_timeout: instr %h not accepted within 8 cycles", instr);
    endtask

    task automatic test_reset();
        bit a, r;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        n_checks++;
        if ({res_valid, res_zero, res_rd, res_data} !== '0) begin
            n_fail++; $display("FAIL reset_res: got v=%b z=%b rd=%0d d=%h want all 0", res_valid, res_zero, res_rd, res_data);
        end
        n_checks++;
        if ({alu_a, alu_b, alu_instr} !== '0) begin
            n_fail++; $display("FAIL reset_alu: got a=%h b=%h i=%h want 0", alu_a, alu_b, alu_instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(a, r);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_int_add();
        int s;
        hostwr(3'd1, 32'hFFFFFFFB);
        hostwr(3'd2, 32'hFFFFFFFE);
        issue(mk(OP_INT_ADD, 3'd3, 3'd1, 3'd2), s);
        idle();
        n_checks++;
        if ({res_valid, res_data, res_rd, res_zero} !== {1'b1, 32'hFFFFFFF9, 3'd3, 1'b0}) begin
            n_fail++; $display("FAIL int_add: got v=%b d=%h rd=%0d z=%b want v=1 d=fffffff9 rd=3 z=0", res_valid, res_data, res_rd, res_zero);
        end
        issue(mk(OP_INT_ADD, 3'd6, 3'd3, 3'd0), s);
        idle();
        n_checks++;
        if (res_data !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL r3_updated: got %h want fffffff9", res_data); end
    endtask

    task automatic test_float_add();
        int s;
        hostwr(3'd1, 32'h404CCCCD);
        hostwr(3'd2, 32'hBFA66666);
        issue(mk(OP_FP_ADD, 3'd4, 3'd1, 3'd2), s);
        idle();
        n_checks++;
        if (res_data !== 32'h3FF33333) begin n_fail++; $display("FAIL float_add: got %h want 3ff33333", res_data); end
    endtask

    task automatic test_zero_flag();
        int s;
        hostwr(3'd1, 32'd5);
        hostwr(3'd2, 32'd5);
        issue(mk(OP_INT_SUB, 3'd4, 3'd1, 3'd2), s);
        idle();
        n_checks++;
        if ({res_data, res_zero, res_rd} !== {32'h0, 1'b1, 3'd4}) begin
            n_fail++; $display("FAIL zero_flag: got d=%h z=%b rd=%0d want d=0 z=1 rd=4", res_data, res_zero, res_rd);
        end
    endtask

    task automatic test_back_to_back();
        int s0, s1, want_stall;
        hostwr(3'd1, 32'hFFFFFFFB);
        hostwr(3'd2, 32'hFFFFFFFE);
        issue(mk(OP_INT_ADD, 3'd3, 3'd1, 3'd2), s0);
        issue(mk(OP_INT_ADD, 3'd5, 3'd3, 3'd3), s1);
        idle();
        n_checks++;
        if ({res_data, res_rd} !== {32'hFFFFFFF2, 3'd5}) begin
            n_fail++; $display("FAIL dep_value: got d=%h rd=%0d want d=fffffff2 rd=5", res_data, res_rd);
        end
        want_stall = FWD ? 0 : 1;
        n_checks++;
        if (s1 != want_stall) begin n_fail++; $display("FAIL dep_stall: got %0d stall cycles want %0d", s1, want_stall); end
    endtask

    task automatic test_collision();
        int s;
        hostwr(3'd1, 32'hFFFFFFFB);
        hostwr(3'd2, 32'hFFFFFFFE);
        issue(mk(OP_INT_ADD, 3'd3, 3'd1, 3'd2), s);
        hostwr(3'd3, 32'h12345678);   // same edge as writeback to r3
        issue(mk(OP_INT_ADD, 3'd6, 3'd3, 3'd0), s);
        idle();
        n_checks++;
        if (res_data !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL collision_same: got %h want fffffff9", res_data); end
        issue(mk(OP_INT_ADD, 3'd3, 3'd1, 3'd2), s);
        hostwr(3'd7, 32'h0000AAAA);   // different index, same edge
        issue(mk(OP_INT_ADD, 3'd6, 3'd7, 3'd0), s);
        idle();
        n_checks++;
        if (res_data !== 32'h0000AAAA) begin n_fail++; $display("FAIL collision_diff: got %h want 0000aaaa", res_data); end
    endtask

    task automatic test_random();
        bit a, r;
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = mk(ops[$urandom_range(0, 7)], 3'($urandom), 3'($urandom), 3'($urandom));
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 3'($urandom);
            wr_data  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            cycle(a, r);
        end
        repeat (2) idle();
    endtask

    task automatic test_reset_midop();
        int s;
        bit a, r;
        hostwr(3'd1, 32'h11);
        issue(mk(OP_INT_ADD, 3'd2, 3'd1, 3'd1), s);
        rst_n = 1'b0;                  // ex_valid is 1 here
        #1;
        n_checks++;
        if ({in_ready, alu_a, alu_b, alu_instr} !== '0) begin
            n_fail++; $display("FAIL midop_reset_alu: got rdy=%b a=%h b=%h i=%h want 0", in_ready, alu_a, alu_b, alu_instr);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({res_valid, res_data} !== '0) begin
            n_fail++; $display("FAIL midop_no_result: got v=%b d=%h want 0", res_valid, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(a, r);
        issue(mk(OP_INT_X7, 3'd6, 3'd1, 3'd2), s);
        idle();
        n_checks++;
        if ({res_valid, res_data} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL midop_cleared: got v=%b d=%h want v=1 d=0", res_valid, res_data);
        end
    endtask

    initial begin
        test_reset();
        test_int_add();
        test_float_add();
        test_zero_flag();
        test_back_to_back();
        test_collision();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
